// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stage indices for the RV32IM pipeline controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    MD_WAIT,
    MD_HOLD
  } state_t;

  localparam int unsigned NSTAGE = 4;
  localparam int unsigned IFID   = 0;
  localparam int unsigned IDEX   = 1;
  localparam int unsigned EXMEM  = 2;
  localparam int unsigned MEMWB  = 3;

  typedef logic [NSTAGE-1:0] stage_vec_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipeline-register controls exchanged between the core and pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_is_md;
  logic              ex_redirect;
  logic              dmem_wait;
  logic              md_done;
  logic              md_start;
  logic              en_pc;
  logic              en_ifid;
  logic              en_idex;
  logic              en_exmem;
  logic              en_memwb;
  logic              flush_ifid;
  logic              flush_idex;
  logic              flush_memwb;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_is_md, ex_redirect, dmem_wait, md_done,
    input  md_start, en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_memwb, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_is_md, ex_redirect, dmem_wait, md_done,
    output md_start, en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_memwb, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with asynchronous active-high clear.
module sat_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use, redirect, dmem wait and mul/div sequencing.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic     clk,
  input  logic     rst,
  pipe_ctrl_if.slave bus
);

  state_t            state_q;
  state_t            state_d;
  stage_vec_t        en;
  logic              en_pc;
  logic              flush_ifid;
  logic              flush_idex;
  logic              flush_memwb;
  logic              md_start;
  logic              redirect_take;
  logic              load_use;
  logic [REG_AW-1:0] ex_rd;

  assign ex_rd = bus.ex_rd;

  assign load_use = bus.ex_mem_read && (ex_rd != '0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == ex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    en            = '0;
    en_pc         = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    flush_memwb   = 1'b0;
    md_start      = 1'b0;
    redirect_take = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.dmem_wait) begin
          en = '0;
        end else if (bus.ex_redirect) begin
          en            = '1;
          en_pc         = 1'b1;
          flush_ifid    = 1'b1;
          flush_idex    = 1'b1;
          redirect_take = 1'b1;
        end else if (bus.ex_is_md) begin
          md_start     = 1'b1;
          en[MEMWB]    = 1'b1;
          flush_memwb  = 1'b1;
          state_d      = MD_WAIT;
        end else if (load_use) begin
          en[IDEX]     = 1'b1;
          en[EXMEM]    = 1'b1;
          en[MEMWB]    = 1'b1;
          flush_idex   = 1'b1;
        end else begin
          en    = '1;
          en_pc = 1'b1;
        end
      end

      MD_WAIT: begin
        en[MEMWB]   = 1'b1;
        flush_memwb = 1'b1;
        // Done while MEM is stalled: the md unit holds its result, so park in MD_HOLD.
        if (bus.md_done) begin
          if (!bus.dmem_wait) begin
            en          = '1;
            en_pc       = 1'b1;
            flush_memwb = 1'b0;
            state_d     = RUN;
          end else begin
            state_d     = MD_HOLD;
          end
        end
      end

      MD_HOLD: begin
        if (!bus.dmem_wait) begin
          en      = '1;
          en_pc   = 1'b1;
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase

    if (rst) begin
      en            = '0;
      en_pc         = 1'b0;
      flush_ifid    = 1'b0;
      flush_idex    = 1'b0;
      flush_memwb   = 1'b0;
      md_start      = 1'b0;
      redirect_take = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~en_pc),
    .cnt (bus.stall_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect_take),
    .cnt (bus.flush_cnt)
  );

  assign bus.md_start    = md_start;
  assign bus.en_pc       = en_pc;
  assign bus.en_ifid     = en[IFID];
  assign bus.en_idex     = en[IDEX];
  assign bus.en_exmem    = en[EXMEM];
  assign bus.en_memwb    = en[MEMWB];
  assign bus.flush_ifid  = flush_ifid;
  assign bus.flush_idex  = flush_idex;
  assign bus.flush_memwb = flush_memwb;

endmodule
